// File: rtl/spram256x16_arbiter.sv
// spram256x16_arbiter
// Two-master round-robin front end for a 256x16 single-port RAM.
// One access at a time: the winner's WE/AD/DI are latched and held on the RAM
// port until RAM_READY arrives or the READY watchdog expires. Completion is
// reported with a one-cycle ACKn (or ERRn on abort) to the winner only.
// Every output comes straight from a flop.
//
//  state | meaning
//  ------+------------------------------------------------------------
//  IDLE  | no access in flight; arbitrates REQ0/REQ1
//  ISSUE | strobes asserted, waiting for RAM_READY or watchdog expiry
//  DONE  | ACK/ERR pulse to the winner, priority handed to the other side
module spram256x16_arbiter #(
  parameter int AW  = 8,
  parameter int DW  = 16,
  parameter int TMO = 15,
  parameter int TW  = 4
) (
  input  logic          CLK,
  input  logic          NRST,
  input  logic          REQ0,
  input  logic          REQ1,
  input  logic          WE0,
  input  logic          WE1,
  input  logic [AW-1:0] AD0,
  input  logic [AW-1:0] AD1,
  input  logic [DW-1:0] DI0,
  input  logic [DW-1:0] DI1,
  output logic          ACK0,
  output logic          ACK1,
  output logic          ERR0,
  output logic          ERR1,
  output logic [DW-1:0] RDATA,
  output logic          BUSY,
  output logic          RAM_CS,
  output logic          RAM_EN,
  output logic          RAM_RD,
  output logic          RAM_WR,
  output logic [AW-1:0] RAM_AD,
  output logic [DW-1:0] RAM_DI,
  input  logic [DW-1:0] RAM_DO,
  input  logic          RAM_READY
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // The timer holds the number of ISSUE cycles spent so far, counting the
  // current one, so expiry at TMO means the strobes were up for TMO cycles.
  localparam logic [TW-1:0] TMO_CNT = TW'(TMO);

  state_t        state_q, state_d;
  logic          pri_q, pri_d;
  logic          win_q, win_d;
  logic          we_q, we_d;
  logic [AW-1:0] ad_q, ad_d;
  logic [DW-1:0] di_q, di_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          cs_q, cs_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic          busy_q, busy_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          err0_q, err0_d;
  logic          err1_q, err1_d;

  logic any_req;
  logic grant1;
  logic expired;

  assign any_req = REQ0 | REQ1;
  // Requester 1 wins when alone, or when both ask and the pointer favours it.
  assign grant1  = REQ1 & (~REQ0 | pri_q);
  assign expired = (timer_q == TMO_CNT);

  // State register
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode; READY is tested before expiry so a late READY still succeeds
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_req) state_d = S_ISSUE;
      S_ISSUE: if (RAM_READY || expired) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; strobes default low so they fall on leaving ISSUE
  always_comb begin
    pri_d   = pri_q;
    win_d   = win_q;
    we_d    = we_q;
    ad_d    = ad_q;
    di_d    = di_q;
    timer_d = timer_q;
    rdata_d = rdata_q;
    cs_d    = 1'b0;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    err0_d  = 1'b0;
    err1_d  = 1'b0;
    busy_d  = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          win_d   = grant1;
          we_d    = grant1 ? WE1 : WE0;
          ad_d    = grant1 ? AD1 : AD0;
          di_d    = grant1 ? DI1 : DI0;
          cs_d    = 1'b1;
          rd_d    = ~we_d;
          wr_d    = we_d;
          timer_d = TW'(1);
        end
      end
      S_ISSUE: begin
        if (RAM_READY) begin
          if (!we_q) rdata_d = RAM_DO;
          ack0_d = ~win_q;
          ack1_d = win_q;
        end else if (expired) begin
          err0_d = ~win_q;
          err1_d = win_q;
        end else begin
          cs_d    = 1'b1;
          rd_d    = ~we_q;
          wr_d    = we_q;
          timer_d = timer_q + 1'b1;
        end
      end
      S_DONE: begin
        pri_d   = ~win_q;
        timer_d = '0;
      end
      default: ;
    endcase
  end

  // Datapath and output flops; reset drops every strobe immediately
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      pri_q   <= 1'b0;
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      ad_q    <= '0;
      di_q    <= '0;
      timer_q <= '0;
      rdata_q <= '0;
      cs_q    <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
    end else begin
      pri_q   <= pri_d;
      win_q   <= win_d;
      we_q    <= we_d;
      ad_q    <= ad_d;
      di_q    <= di_d;
      timer_q <= timer_d;
      rdata_q <= rdata_d;
      cs_q    <= cs_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      err0_q  <= err0_d;
      err1_q  <= err1_d;
    end
  end

  // CS and EN always move together, so one flop drives both pins
  assign RAM_CS = cs_q;
  assign RAM_EN = cs_q;
  assign RAM_RD = rd_q;
  assign RAM_WR = wr_q;
  assign RAM_AD = ad_q;
  assign RAM_DI = di_q;
  assign RDATA  = rdata_q;
  assign BUSY   = busy_q;
  assign ACK0   = ack0_q;
  assign ACK1   = ack1_q;
  assign ERR0   = err0_q;
  assign ERR1   = err1_q;

endmodule

// File: tb/tb_spram256x16_arbiter.sv
// Bench for spram256x16_arbiter. The bench plays both masters and the RAM.
// The RAM model picks a READY latency per access; expectations come from a
// transaction-level view: who should win, how many strobe cycles the access
// lasts (latency+1, capped at TMO), ack vs err, and the memory contents.
module tb_spram256x16_arbiter;
  localparam int AW  = 8;
  localparam int DW  = 16;
  localparam int TMO = 15;
  localparam int TW  = 4;

  localparam int P_IDLE = 0;
  localparam int P_STRB = 1;
  localparam int P_DONE = 2;

  logic          CLK = 1'b0;
  logic          NRST = 1'b0;
  logic          REQ0 = 1'b0, REQ1 = 1'b0, WE0 = 1'b0, WE1 = 1'b0;
  logic [AW-1:0] AD0 = '0, AD1 = '0;
  logic [DW-1:0] DI0 = '0, DI1 = '0;
  logic          ACK0, ACK1, ERR0, ERR1, BUSY;
  logic          RAM_CS, RAM_EN, RAM_RD, RAM_WR;
  logic [DW-1:0] RDATA, RAM_DI;
  logic [AW-1:0] RAM_AD;
  logic [DW-1:0] RAM_DO = '0;
  logic          RAM_READY = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model
  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] rdata_m;
  logic          pri_m;
  int            phase, scnt, a_lat, win;
  logic          a_we;
  logic [AW-1:0] a_ad;
  logic [DW-1:0] a_di;
  logic          done_err;
  int            pend [2];
  bit            auto_req;
  int            req_rate;
  int            force_lat;
  int            grant_log [$];

  always #5 CLK = ~CLK;

  spram256x16_arbiter #(.AW(AW), .DW(DW), .TMO(TMO), .TW(TW)) dut (
    .CLK(CLK), .NRST(NRST),
    .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
    .AD0(AD0), .AD1(AD1), .DI0(DI0), .DI1(DI1),
    .ACK0(ACK0), .ACK1(ACK1), .ERR0(ERR0), .ERR1(ERR1),
    .RDATA(RDATA), .BUSY(BUSY),
    .RAM_CS(RAM_CS), .RAM_EN(RAM_EN), .RAM_RD(RAM_RD), .RAM_WR(RAM_WR),
    .RAM_AD(RAM_AD), .RAM_DI(RAM_DI), .RAM_DO(RAM_DO), .RAM_READY(RAM_READY)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] rnd_ad();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return 8'hFF;
    if (r == 1) return 8'h00;
    return AW'($urandom);
  endfunction

  // READY latency in wait cycles; TMO-1 lands READY on the last allowed cycle
  function automatic int pick_lat();
    int r;
    r = $urandom_range(0, 9);
    case (r)
      0, 1, 2: return 0;
      3:       return 1;
      4:       return 3;
      5:       return $urandom_range(0, 6);
      6:       return TMO - 1;
      7:       return TMO;
      8:       return TMO + 4;
      default: return 2;
    endcase
  endfunction

  task automatic post(input int n, input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] di);
    pend[n] = 1;
    if (n == 0) begin REQ0 = 1'b1; WE0 = we; AD0 = ad; DI0 = di; end
    else        begin REQ1 = 1'b1; WE1 = we; AD1 = ad; DI1 = di; end
  endtask

  // Pending requests hold steady; once granted, the master's inputs are scrambled
  task automatic drive_req(input int n);
    logic          r;
    logic          we;
    logic [AW-1:0] ad;
    logic [DW-1:0] di;
    we = 1'($urandom_range(0, 1));
    ad = rnd_ad();
    di = DW'($urandom);
    if (pend[n] == 1) return;
    if (pend[n] == 0 && auto_req && $urandom_range(1, 100) <= req_rate) begin
      post(n, we, ad, di);
      return;
    end
    r = (pend[n] == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    if (n == 0) begin REQ0 = r; WE0 = we; AD0 = ad; DI0 = di; end
    else        begin REQ1 = r; WE1 = we; AD1 = ad; DI1 = di; end
  endtask

  task automatic step();
    logic [3:0] ae_exp;
    @(negedge CLK);
    case (phase)
      P_IDLE: begin
        if (REQ0 || REQ1) begin
          win   = (REQ0 && REQ1) ? int'(pri_m) : (REQ1 ? 1 : 0);
          a_we  = (win == 1) ? WE1 : WE0;
          a_ad  = (win == 1) ? AD1 : AD0;
          a_di  = (win == 1) ? DI1 : DI0;
          a_lat = (force_lat >= 0) ? force_lat : pick_lat();
          scnt  = 1;
          pend[win] = 2;
          grant_log.push_back(win);
          phase = P_STRB;
        end
      end
      P_STRB: begin
        if (RAM_READY || scnt == TMO) begin
          done_err = !RAM_READY;
          phase    = P_DONE;
        end else begin
          scnt++;
        end
      end
      default: phase = P_IDLE;
    endcase

    case (phase)
      P_IDLE: check_eq("idle_ctl",
        32'({RAM_CS, RAM_EN, RAM_RD, RAM_WR, BUSY, ACK0, ACK1, ERR0, ERR1}), 32'd0);
      P_STRB: begin
        check_eq("strb_ctl",
          32'({RAM_CS, RAM_EN, RAM_RD, RAM_WR, BUSY, ACK0, ACK1, ERR0, ERR1}),
          32'({1'b1, 1'b1, ~a_we, a_we, 1'b1, 4'b0000}));
        check_eq("strb_ad", 32'(RAM_AD), 32'(a_ad));
        check_eq("strb_di", 32'(RAM_DI), 32'(a_di));
      end
      default: begin
        if (!done_err) begin
          if (a_we) mem[a_ad] = a_di;
          else      rdata_m   = mem[a_ad];
        end
        ae_exp = {(!done_err && win == 0), (!done_err && win == 1),
                  (done_err && win == 0), (done_err && win == 1)};
        check_eq("done_ctl", 32'({RAM_CS, RAM_EN, RAM_RD, RAM_WR, BUSY}), 32'(5'b00001));
        check_eq(done_err ? "done_err" : "done_ack", 32'({ACK0, ACK1, ERR0, ERR1}), 32'(ae_exp));
        pri_m     = (win == 0);
        pend[win] = 0;
      end
    endcase
    check_eq("rdata", 32'(RDATA), 32'(rdata_m));

    drive_req(0);
    drive_req(1);
    if (phase == P_STRB) begin
      RAM_READY = (scnt == a_lat + 1);
      RAM_DO    = a_we ? DW'($urandom) : mem[a_ad];
    end else begin
      RAM_READY = 1'($urandom_range(0, 1));
      RAM_DO    = DW'($urandom);
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (!(phase == P_IDLE && pend[0] == 0 && pend[1] == 0) && k < 200) begin
      step();
      k++;
    end
    check_eq("drain_bound", 32'(k >= 200), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq(tag, 32'({RAM_CS, RAM_EN, RAM_RD, RAM_WR, BUSY, ACK0, ACK1, ERR0, ERR1}), 32'd0);
    check_eq({tag, "_rdata"}, 32'(RDATA), 32'd0);
    check_eq({tag, "_ad_di"}, 32'({RAM_AD, RAM_DI}), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed time limit reached, expected run to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
    pri_m = 1'b0; rdata_m = '0; phase = P_IDLE; scnt = 0; a_lat = 0; win = 0;
    a_we = 1'b0; a_ad = '0; a_di = '0; done_err = 1'b0;
    pend[0] = 0; pend[1] = 0; auto_req = 1'b0; req_rate = 0; force_lat = -1;

    repeat (3) @(negedge CLK);
    check_reset_outputs("reset");

    // both masters requesting straight out of reset, re-requesting at once
    post(0, 1'b1, 8'h01, 16'h1111);
    post(1, 1'b1, 8'h02, 16'h2222);
    NRST = 1'b1;
    auto_req = 1'b1; req_rate = 100; force_lat = 0;
    k = 0;
    while (grant_log.size() < 4 && k < 100) begin step(); k++; end
    auto_req = 1'b0;
    drain();
    check_eq("rr_count", 32'(grant_log.size() >= 4), 32'd1);
    check_eq("rr_order0", 32'(grant_log[0]), 32'd0);
    check_eq("rr_order1", 32'(grant_log[1]), 32'd1);
    check_eq("rr_order2", 32'(grant_log[2]), 32'd0);
    check_eq("rr_order3", 32'(grant_log[3]), 32'd1);

    // single write, READY immediately
    post(0, 1'b1, 8'h12, 16'hBEEF); force_lat = 0; drain();
    // read-back with three wait cycles
    post(1, 1'b0, 8'h12, 16'h0000); force_lat = 3; drain();
    check_eq("readback", 32'(RDATA), 32'h0000BEEF);
    // READY never comes: error, RDATA untouched
    post(0, 1'b0, 8'h34, 16'h0000); force_lat = 1000; drain();
    check_eq("timeout_rdata", 32'(RDATA), 32'h0000BEEF);
    // READY on the final allowed cycle, extreme addresses
    post(1, 1'b1, 8'hFF, 16'hA5A5); force_lat = 0; drain();
    post(0, 1'b0, 8'hFF, 16'h0000); force_lat = TMO - 1; drain();
    check_eq("edge_ff", 32'(RDATA), 32'h0000A5A5);
    post(0, 1'b1, 8'h00, 16'h5A5A); force_lat = 0; drain();
    post(1, 1'b0, 8'h00, 16'h0000); force_lat = TMO - 1; drain();
    check_eq("edge_00", 32'(RDATA), 32'h00005A5A);

    // reset in the middle of an access after the pointer moved to 1
    post(0, 1'b1, 8'h40, 16'h1234); force_lat = 0; drain();
    post(1, 1'b0, 8'h77, 16'h4321); force_lat = 1000;
    repeat (3) step();
    #2 NRST = 1'b0;
    #1 check_reset_outputs("async_rst");
    REQ0 = 1'b0; REQ1 = 1'b0; RAM_READY = 1'b0;
    phase = P_IDLE; pend[0] = 0; pend[1] = 0; pri_m = 1'b0; rdata_m = '0;
    @(negedge CLK);
    @(negedge CLK);
    NRST = 1'b1;
    post(0, 1'b0, 8'h40, 16'h0000);
    post(1, 1'b0, 8'h12, 16'h0000);
    force_lat = 0;
    drain();
    check_eq("post_rst_first", 32'(grant_log[grant_log.size()-2]), 32'd0);
    check_eq("post_rst_second", 32'(grant_log[grant_log.size()-1]), 32'd1);

    // random traffic
    force_lat = -1; auto_req = 1'b1; req_rate = 30;
    repeat (3000) step();
    auto_req = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
